// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: arbitrates two cores' I/D traffic onto one RAM and drives MSI snoops
module coherence_bus_ctrl #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [CPUS-1:0]          iREN_i,
   input  logic [CPUS*WORD_W-1:0]   iaddr_i,
   output logic [CPUS-1:0]          iwait_o,
   output logic [CPUS*WORD_W-1:0]   iload_o,
   input  logic [CPUS-1:0]          dREN_i,
   input  logic [CPUS-1:0]          dWEN_i,
   input  logic [CPUS*WORD_W-1:0]   daddr_i,
   input  logic [CPUS*WORD_W-1:0]   dstore_i,
   output logic [CPUS-1:0]          dwait_o,
   output logic [CPUS*WORD_W-1:0]   dload_o,
   input  logic [CPUS-1:0]          cctrans_i,
   input  logic [CPUS-1:0]          ccwrite_i,
   output logic [CPUS-1:0]          ccwait_o,
   output logic [CPUS-1:0]          ccinv_o,
   output logic [CPUS*WORD_W-1:0]   ccsnoopaddr_o,
   output logic                     ramREN_o,
   output logic                     ramWEN_o,
   output logic [WORD_W-1:0]        ramaddr_o,
   output logic [WORD_W-1:0]        ramstore_o,
   input  logic [WORD_W-1:0]        ramload_i,
   input  logic                     ramwait_i
);
   typedef enum logic [2:0] {IDLE, IFETCH, DWRITE, SNOOP, C2C, DREAD} state_t;
   state_t state_q, state_d;
   logic rr_q, rr_d, req_q, req_d, cnt_q, cnt_d, hold_q, hold_d;
   logic r, o, g;
   logic [CPUS-1:0][WORD_W-1:0] iaddr, daddr, dstore, iload, dload, snoop;
   logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
   function automatic logic pick(input logic [1:0] v, input logic p);
      return (&v) ? ~p : v[1];
   endfunction
   assign iaddr = iaddr_i;
   assign daddr = daddr_i;
   assign dstore = dstore_i;
   assign r = req_q;
   assign o = ~req_q;
   assign g = |dWEN_i ? pick(dWEN_i, rr_q) : |dREN_i ? pick(dREN_i, rr_q) : pick(iREN_i, rr_q);
   assign iwait_o = iwait;
   assign iload_o = iload;
   assign dwait_o = dwait;
   assign dload_o = dload;
   assign ccwait_o = ccwait;
   assign ccinv_o = ccinv;
   assign ccsnoopaddr_o = snoop;
   // state, round-robin pointer, granted core, C2C word count and writeback hold
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         rr_q <= 1'b0;
         req_q <= 1'b0;
         cnt_q <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         req_q <= req_d;
         cnt_q <= cnt_d;
         hold_q <= hold_d;
      end
   end
   // arbitration, next state and all bus/snoop outputs; completions are gated by a still-present request
   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      req_d = req_q;
      cnt_d = cnt_q;
      hold_d = 1'b0;
      iwait = '1;
      dwait = '1;
      iload = '0;
      dload = '0;
      ccwait = '0;
      ccinv = '0;
      snoop = '0;
      ramREN_o = 1'b0;
      ramWEN_o = 1'b0;
      ramaddr_o = '0;
      ramstore_o = '0;
      case (state_q)
         IDLE: begin
            if (hold_q && dWEN_i[r]) begin
               state_d = DWRITE;
            end else if (|{dWEN_i, dREN_i, iREN_i}) begin
               req_d = g;
               rr_d = g;
               state_d = |dWEN_i ? DWRITE : |dREN_i ? (cctrans_i[g] ? SNOOP : DREAD) : IFETCH;
            end
         end
         IFETCH: begin
            ramREN_o = 1'b1;
            ramaddr_o = iaddr[r];
            if (!ramwait_i) begin
               iwait[r] = ~iREN_i[r];
               iload[r] = iREN_i[r] ? ramload_i : '0;
               state_d = IDLE;
            end
         end
         DWRITE: begin
            ramWEN_o = 1'b1;
            ramaddr_o = daddr[r];
            ramstore_o = dstore[r];
            if (!ramwait_i) begin
               dwait[r] = ~dWEN_i[r];
               hold_d = 1'b1;
               state_d = IDLE;
            end
         end
         SNOOP: begin
            ccwait[o] = 1'b1;
            ccinv[o] = ccwrite_i[r];
            snoop[o] = daddr[r];
            if (ccwrite_i[o]) begin
               cnt_d = 1'b0;
               state_d = C2C;
            end else if (cctrans_i[o]) begin
               state_d = DREAD;
            end
         end
         C2C: begin
            ccwait[o] = 1'b1;
            ccinv[o] = ccwrite_i[r];
            snoop[o] = daddr[r];
            dload[r] = dstore[o];
            ramWEN_o = dWEN_i[o];
            ramaddr_o = daddr[o];
            ramstore_o = dstore[o];
            if (dWEN_i[o] && !ramwait_i) begin
               dwait[o] = 1'b0;
               dwait[r] = !(dREN_i[r] && daddr[o] == daddr[r]);
               cnt_d = 1'b1;
               state_d = cnt_q ? IDLE : C2C;
            end
         end
         DREAD: begin
            ramREN_o = 1'b1;
            ramaddr_o = daddr[r];
            if (!ramwait_i) begin
               dwait[r] = ~dREN_i[r];
               dload[r] = dREN_i[r] ? ramload_i : '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: per-cycle vector tables for coherence_bus_ctrl plus reset sequences
module tb_coherence_bus_ctrl;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   logic [1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
   logic [63:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
   logic ramREN, ramWEN, ramwait;
   logic [31:0] ramaddr, ramstore, ramload;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic [1:0] iren, dren, dwen, cct, ccw;
      logic rw;
      logic [31:0] a0, a1, s0, s1, rl;
      logic [1:0] e_iw, e_dw, e_cw, e_ci;
      logic e_ren, e_wen;
      logic [31:0] e_ra, e_rs;
      logic [63:0] e_il, e_dl, e_sa;
   } vec_t;
   vec_t tv[25];
   vec_t hv[10];
   vec_t idle_v;
   coherence_bus_ctrl dut (
      .CLK(CLK), .nRST(nRST),
      .iREN_i(iREN), .iaddr_i(iaddr), .iwait_o(iwait), .iload_o(iload),
      .dREN_i(dREN), .dWEN_i(dWEN), .daddr_i(daddr), .dstore_i(dstore),
      .dwait_o(dwait), .dload_o(dload),
      .cctrans_i(cctrans), .ccwrite_i(ccwrite), .ccwait_o(ccwait), .ccinv_o(ccinv),
      .ccsnoopaddr_o(ccsnoopaddr),
      .ramREN_o(ramREN), .ramWEN_o(ramWEN), .ramaddr_o(ramaddr), .ramstore_o(ramstore),
      .ramload_i(ramload), .ramwait_i(ramwait)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input int idx, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %h want %h", idx, nm, act, exp);
      end
   endtask
   task automatic drive(input vec_t v);
      iREN = v.iren;
      dREN = v.dren;
      dWEN = v.dwen;
      cctrans = v.cct;
      ccwrite = v.ccw;
      ramwait = v.rw;
      ramload = v.rl;
      iaddr = {v.a1, v.a0};
      daddr = {v.a1, v.a0};
      dstore = {v.s1, v.s0};
   endtask
   task automatic check_out(input vec_t v, input int idx);
      chk(idx, "iwait", {62'd0, iwait}, {62'd0, v.e_iw});
      chk(idx, "dwait", {62'd0, dwait}, {62'd0, v.e_dw});
      chk(idx, "ccwait", {62'd0, ccwait}, {62'd0, v.e_cw});
      chk(idx, "ccinv", {62'd0, ccinv}, {62'd0, v.e_ci});
      chk(idx, "ramREN", {63'd0, ramREN}, {63'd0, v.e_ren});
      chk(idx, "ramWEN", {63'd0, ramWEN}, {63'd0, v.e_wen});
      chk(idx, "ramaddr", {32'd0, ramaddr}, {32'd0, v.e_ra});
      chk(idx, "ramstore", {32'd0, ramstore}, {32'd0, v.e_rs});
      chk(idx, "iload", iload, v.e_il);
      chk(idx, "dload", dload, v.e_dl);
      chk(idx, "ccsnoopaddr", ccsnoopaddr, v.e_sa);
   endtask
   task automatic run(input vec_t v, input int idx);
      @(negedge CLK);
      drive(v);
      #1;
      check_out(v, idx);
   endtask
   initial begin
      idle_v = '{0,0,0,0,0,0, 0,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[0]  = '{0,0,0,0,0,0, 0,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[1]  = '{1,0,0,0,0,1, 'h100,0,0,0,'h8C010004, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[2]  = '{1,0,0,0,0,1, 'h100,0,0,0,'h8C010004, 3,3,0,0,1,0, 'h100,0, 0,0,0};
      tv[3]  = '{1,0,0,0,0,0, 'h100,0,0,0,'h8C010004, 2,3,0,0,1,0, 'h100,0, 64'h8C010004,0,0};
      tv[4]  = '{0,0,0,0,0,0, 0,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[5]  = '{2,0,1,0,0,0, 'h40,'h200,'hDEAD,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[6]  = '{2,0,1,0,0,0, 'h40,'h200,'hDEAD,0,0, 3,2,0,0,0,1, 'h40,'hDEAD, 0,0,0};
      tv[7]  = '{2,0,0,0,0,0, 0,'h200,0,0,'h1234, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[8]  = '{2,0,0,0,0,0, 0,'h200,0,0,'h1234, 1,3,0,0,1,0, 'h200,0, 64'h00001234_00000000,0,0};
      tv[9]  = '{0,1,0,1,1,1, 'h80,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[10] = '{0,1,0,1,1,1, 'h80,0,0,0,0, 3,3,2,2,0,0, 0,0, 0,0,64'h00000080_00000000};
      tv[11] = '{0,1,0,3,1,1, 'h80,0,0,0,0, 3,3,2,2,0,0, 0,0, 0,0,64'h00000080_00000000};
      tv[12] = '{0,1,0,1,1,0, 'h80,0,0,0,'h5555AAAA, 3,2,0,0,1,0, 'h80,0, 0,64'h5555AAAA,0};
      tv[13] = '{0,2,0,2,0,1, 0,'h84,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[14] = '{0,2,0,2,1,1, 0,'h84,0,0,0, 3,3,1,0,0,0, 0,0, 0,0,'h84};
      tv[15] = '{0,2,1,2,1,0, 'h80,'h84,'hA,0,0, 3,2,1,0,0,1, 'h80,'hA, 0,64'h0000000A_00000000,'h84};
      tv[16] = '{0,2,1,2,1,1, 'h84,'h84,'hB,0,0, 3,3,1,0,0,1, 'h84,'hB, 0,64'h0000000B_00000000,'h84};
      tv[17] = '{0,2,1,2,1,0, 'h84,'h84,'hB,0,0, 3,0,1,0,0,1, 'h84,'hB, 0,64'h0000000B_00000000,'h84};
      tv[18] = '{0,0,0,0,0,0, 0,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[19] = '{0,3,0,0,0,0, 'h10,'h20,0,0,'h77, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[20] = '{0,3,0,0,0,0, 'h10,'h20,0,0,'h77, 3,2,0,0,1,0, 'h10,0, 0,64'h77,0};
      tv[21] = '{0,3,0,0,0,0, 'h10,'h20,0,0,'h77, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[22] = '{0,3,0,0,0,0, 'h10,'h20,0,0,'h77, 3,1,0,0,1,0, 'h20,0, 0,64'h00000077_00000000,0};
      tv[23] = '{0,3,0,0,0,0, 'h10,'h20,0,0,'h77, 3,3,0,0,0,0, 0,0, 0,0,0};
      tv[24] = '{0,3,0,0,0,1, 'h10,'h20,0,0,'h77, 3,3,0,0,1,0, 'h10,0, 0,0,0};
      hv[0] = '{0,0,3,0,0,0, 'h30,'h34,1,2,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      hv[1] = '{0,0,3,0,0,0, 'h30,'h34,1,2,0, 3,1,0,0,0,1, 'h34,2, 0,0,0};
      hv[2] = '{0,0,3,0,0,0, 'h30,'h38,1,3,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      hv[3] = '{0,0,3,0,0,0, 'h30,'h38,1,3,0, 3,1,0,0,0,1, 'h38,3, 0,0,0};
      hv[4] = '{0,0,1,0,0,0, 'h30,0,1,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      hv[5] = '{0,0,1,0,0,0, 'h30,0,1,0,0, 3,2,0,0,0,1, 'h30,1, 0,0,0};
      hv[6] = '{1,0,0,0,0,1, 'h100,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      hv[7] = '{0,0,0,0,0,1, 'h100,0,0,0,0, 3,3,0,0,1,0, 'h100,0, 0,0,0};
      hv[8] = '{0,0,0,0,0,0, 'h100,0,0,0,'h99, 3,3,0,0,1,0, 'h100,0, 0,0,0};
      hv[9] = '{0,0,0,0,0,0, 0,0,0,0,0, 3,3,0,0,0,0, 0,0, 0,0,0};
      drive(idle_v);
      #2;
      check_out(idle_v, -1);
      #1 nRST = 1'b1;
      for (int i = 0; i < 25; i++) run(tv[i], i);
      #1 nRST = 1'b0;
      #1;
      check_out(idle_v, -2);
      @(negedge CLK);
      drive(idle_v);
      nRST = 1'b1;
      for (int i = 0; i < 10; i++) run(hv[i], 100 + i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
